shift_unit: RTL

Parametrised, pipelined barrel-shift execution unit for the open_mips core. It replaces the single-cycle 32-bit shifter in the EX stage and supports configurable data width, configurable pipeline depth, and a rotate-right mode. It uses a valid/ready handshake with back-pressure, a sequence tag carried through the pipeline, and a synchronous flush for branch or exception squash.

---
 rtl/shift_unit.sv | 127 ++++++++++++
 1 files changed

// File: rtl/shift_unit.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROTR) for the open_mips EX stage.
// The log-shifter levels are spread over STAGES register stages that advance or stall together.

module shift_stage #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int STAGES  = 1,
  parameter int IDX     = 0
) (
  input  logic [1:0]         op,
  input  logic               sign,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   din,
  output logic [WIDTH-1:0]   dout
);
  // Level k shifts by 2^k and belongs to stage floor(k*STAGES/SHAMT_W).
  always_comb begin
    dout = din;
    for (int k = 0; k < SHAMT_W; k++) begin
      if (((k * STAGES) / SHAMT_W) == IDX && shamt[k]) begin
        case (op)
          2'b00:   dout = dout << (1 << k);
          2'b01:   dout = dout >> (1 << k);
          // Fill from the original operand's sign, not the partial result.
          2'b10:   dout = (dout >> (1 << k)) | (sign ? ~({WIDTH{1'b1}} >> (1 << k)) : '0);
          default: dout = (dout >> (1 << k)) | (dout << (WIDTH - (1 << k)));
        endcase
      end
    end
  end
endmodule

module shift_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH),
  parameter int STAGES  = 1,
  parameter int TAG_W   = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_op,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [TAG_W-1:0]   in_tag,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag,
  output logic               busy
);
  logic              en;
  logic [STAGES:1]   vld_pipe;

  assign out_valid = vld_pipe[STAGES];
  assign en        = !out_valid || out_ready;
  assign in_ready  = en;
  assign busy      = |vld_pipe;

  // Whole pipeline moves as a unit; bubbles are kept, flush wins over everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       vld_pipe <= '0;
    else if (flush) vld_pipe <= '0;
    else if (en)    vld_pipe <= STAGES'({vld_pipe, in_valid});
  end

  for (genvar g = 0; g < STAGES; g++) begin : stg
    logic [1:0]         op_i;
    logic               sgn_i;
    logic [SHAMT_W-1:0] sh_i;
    logic [TAG_W-1:0]   tag_i, tag_q;
    logic [WIDTH-1:0]   dat_i, dat_o, dat_q;

    if (g == 0) begin : head
      assign op_i  = in_op;
      assign sgn_i = in_data[WIDTH-1];
      assign sh_i  = in_shamt;
      assign tag_i = in_tag;
      assign dat_i = in_data;
    end else begin : link
      assign op_i  = stg[g-1].mid.op_q;
      assign sgn_i = stg[g-1].mid.sgn_q;
      assign sh_i  = stg[g-1].mid.sh_q;
      assign tag_i = stg[g-1].tag_q;
      assign dat_i = stg[g-1].dat_q;
    end

    shift_stage #(
      .WIDTH(WIDTH), .SHAMT_W(SHAMT_W), .STAGES(STAGES), .IDX(g)
    ) u_lvl (
      .op(op_i), .sign(sgn_i), .shamt(sh_i), .din(dat_i), .dout(dat_o)
    );

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        dat_q <= '0;
        tag_q <= '0;
      end else if (en) begin
        dat_q <= dat_o;
        tag_q <= tag_i;
      end
    end

    // Control fields are only needed by later stages, so the last stage drops them.
    if (g < STAGES - 1) begin : mid
      logic [1:0]         op_q;
      logic               sgn_q;
      logic [SHAMT_W-1:0] sh_q;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          op_q  <= '0;
          sgn_q <= 1'b0;
          sh_q  <= '0;
        end else if (en) begin
          op_q  <= op_i;
          sgn_q <= sgn_i;
          sh_q  <= sh_i;
        end
      end
    end
  end

  assign out_data = stg[STAGES-1].dat_q;
  assign out_tag  = stg[STAGES-1].tag_q;
endmodule
